da_fir5_ctrl: RTL
=================

// Module: da_fir5_ctrl
// PURPOSE
//  Sequencer for a 5-tap bit-serial distributed-arithmetic FIR, y[n]=1x[n]+3x[n-1]+5x[n-2]+7x[n-3]+9x[n-4].
//  Accepts one parallel sample, keeps the 5-sample delay line and scans it LSB-first, one bit-plane per clock.
//  Drives a registered DA coefficient table and runs the shift/add accumulator, including the sign-bit subtract.
//  Sits between the sample source and the filter-output consumer.
// PARAMETERS
//  B     8   sample width, two's complement; also the number of bit-planes scanned per sample
//  LAT   3   clocks from table address presented to table data valid (table is fully registered)
//  WY    13  output width, signed; holds 25*2^(B-1)
// PORTS
//  clk      in   1   rising-edge clock
//  reset    in   1   synchronous, active-low reset
//  x_in     in   B   input sample, signed
//  x_valid  in   1   x_in is valid
//  x_ready  out  1   controller accepts x_in this cycle (x_valid & x_ready = accept)
//  y_out    out  WY  filter result, signed; holds its value between results
//  y_valid  out  1   one-cycle pulse, y_out updated this cycle
//  busy     out  1   high in any state other than IDLE
// BEHAVIOUR
//  Reset (reset=0 at clk edge): state=IDLE, delay line=0, acc=0, bit counter=0, address pipe valid bits=0,
//   y_out=0, y_valid=0, x_ready=0 during reset, busy=0. Reset wins over every other event, also mid-scan.
//  FSM states and transitions:
//   IDLE   -> LOAD on accept
//   LOAD   -> ISSUE after 1 cycle
//   ISSUE  -> DRAIN after B cycles
//   DRAIN  -> DONE after LAT cycles
//   DONE   -> IDLE after 1 cycle
//  x_ready = (state==IDLE) & reset. x_valid is ignored in every other state; there is no sample queue.
//  LOAD: shift the delay line, tap0<=x_in, tapi<=tap(i-1); clear acc; k=0.
//  ISSUE, cycle k=0..B-1: table address bit i = bit k of tap i, so tap0 maps to coefficient 1 and tap4 to coefficient 9.
//   Push (valid=1, k) into a LAT-deep tag pipe so it aligns with the table data.
//  Accumulate when the tag pipe output is valid, with T = 5-bit unsigned table data, zero-extended to WY:
//   k < B-1: acc <= acc + (T<<k)
//   k = B-1: acc <= acc - (T<<(B-1))   (two's-complement sign plane)
//  Last accumulate lands on the final DRAIN cycle. DONE: y_out<=acc and y_valid=1 for this cycle only.
//  Latency from accept edge to y_valid: 1+B+LAT+1 = 13 clocks (defaults). Throughput: 1 sample per 14 clocks.
//  Arithmetic: acc is WY bits signed; the defaults never overflow (range -3200..3175). Wider B needs WY >= B+5.
//  Delay line persists across samples. It is cleared only by reset.
//  Table address is held at 0 outside ISSUE. Table data outside valid tag slots is ignored.
// STRUCTURE
//  Shared package/header: COEF = {1,3,5,7,9}, default B, LAT, WY, FSM state encodings (IDLE, LOAD, ISSUE, DRAIN, DONE).
//  Sub-module da_lut5: 5-bit address in, 5-bit sum-of-selected-coefficients out, LAT registered stages.
//   It is instantiated inside this block. The tag pipe depth must equal the da_lut5 latency.
//  The top level holds the FSM, delay line, bit-plane mux, tag pipe and accumulator.
// TESTING
//  1. Impulse: x = 1,0,0,0,0,0 (one accept each) -> y = 1,3,5,7,9,0. Each y_valid arrives 13 clocks after its accept.
//  2. Negative full scale: x = -128 fed 5 times -> y = -128,-512,-1152,-2048,-3200.
//  3. Positive full scale: x = 127 fed 5 times -> final y = 3175. Mixed signs: x = 1,-1 -> y = 1 then 2.
//  4. Handshake: x_valid held high for 100 clocks -> exactly one accept per 14 clocks. x_ready=0 while busy.
//     Samples presented while busy are never consumed.
//  5. Reset mid-ISSUE (k=4): no y_valid follows; y_out=0; delay line cleared. The next impulse reproduces test 1.
//  6. Idle hold: after a result, 50 idle clocks -> y_out stable, y_valid=0, busy=0, table address=0.

Source files
------------

// File: rtl/da_fir5_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : da_fir5_ctrl_pkg
//  Description : Shared definitions for the 5-tap distributed-arithmetic FIR
//                sequencer: filter coefficients, default widths/latency,
//                FSM state encoding and the DA table content function.
//  Revision    : 1.0 - initial release
// ============================================================================
package da_fir5_ctrl_pkg;

    // Default sample width (also the number of bit-planes scanned per sample)
    localparam int B_DEF   = 8;
    // Default coefficient-table latency in clocks
    localparam int LAT_DEF = 3;
    // Default signed output width, large enough for 25 * 2^(B-1)
    localparam int WY_DEF  = 13;

    // Tap weights, index 0 is the newest sample
    localparam int NTAPS = 5;
    localparam logic [4:0] COEF [NTAPS] = '{5'd1, 5'd3, 5'd5, 5'd7, 5'd9};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // DA table entry: sum of the coefficients whose address bit is set.
    // The largest entry is 1+3+5+7+9 = 25, which fits in 5 bits.
    function automatic logic [4:0] coef_sum(input logic [4:0] addr);
        logic [4:0] sum;
        sum = '0;
        for (int i = 0; i < NTAPS; i++) begin
            if (addr[i]) begin
                sum = sum + COEF[i];
            end
        end
        return sum;
    endfunction

endpackage : da_fir5_ctrl_pkg
`default_nettype wire

// File: rtl/da_fir5_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : da_fir5_ctrl_if
//  Description : Sample-in / result-out bundle of the DA FIR sequencer.
//                master : sample source + result consumer side
//                slave  : the sequencer
//  Signals     : x_in/x_valid/x_ready  - sample handshake (accept = valid&ready)
//                y_out/y_valid         - result, y_valid is a one-cycle pulse
//                busy                  - sequencer not idle
//                tbl_addr              - current DA table address (observation)
//  Revision    : 1.0 - initial release
// ============================================================================
interface da_fir5_ctrl_if #(
    parameter int B  = 8,
    parameter int WY = 13
);
    logic signed [B-1:0]  x_in;
    logic                 x_valid;
    logic                 x_ready;
    logic signed [WY-1:0] y_out;
    logic                 y_valid;
    logic                 busy;
    logic [4:0]           tbl_addr;

    modport master (
        output x_in, x_valid,
        input  x_ready, y_out, y_valid, busy, tbl_addr
    );

    modport slave (
        input  x_in, x_valid,
        output x_ready, y_out, y_valid, busy, tbl_addr
    );

endinterface : da_fir5_ctrl_if
`default_nettype wire

// File: rtl/da_fir5_ctrl_lut5.sv
`default_nettype none
// ============================================================================
//  Module      : da_lut5
//  Description : Fully registered DA coefficient table. Output is the sum of
//                the coefficients selected by the 5-bit address, valid LAT
//                clocks after the address is presented.
//  Ports       : clk     - rising-edge clock
//                reset   - synchronous active-low reset
//                addr_i  - table address, bit i selects tap i
//                data_o  - selected-coefficient sum (unsigned, 5 bits)
//  Revision    : 1.0 - initial release
// ============================================================================
module da_lut5
    import da_fir5_ctrl_pkg::*;
#(
    parameter int LAT = LAT_DEF
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic [4:0] addr_i,
    output logic [4:0]      data_o
);

    logic [4:0] stage_q [LAT];

    // First stage performs the lookup; remaining stages only delay it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stage_q[0] <= '0;
        end else begin
            stage_q[0] <= coef_sum(addr_i);
        end
    end

    for (genvar g = 1; g < LAT; g++) begin : g_stage
        always_ff @(posedge clk) begin
            if (!reset) begin
                stage_q[g] <= '0;
            end else begin
                stage_q[g] <= stage_q[g-1];
            end
        end
    end

    assign data_o = stage_q[LAT-1];

endmodule : da_lut5
`default_nettype wire

// File: rtl/da_fir5_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : da_fir5_ctrl
//  Description : Sequencer for a 5-tap bit-serial distributed-arithmetic FIR,
//                y[n] = 1x[n] + 3x[n-1] + 5x[n-2] + 7x[n-3] + 9x[n-4].
//                Accepts one sample, shifts it into the delay line, scans the
//                taps LSB-first one bit-plane per clock through the DA table
//                and shift/adds the table output (subtracting the sign plane).
//  Ports       : clk   - rising-edge clock
//                reset - synchronous active-low reset
//                bus   - slave side of da_fir5_ctrl_if (sample in, result out)
//  Revision    : 1.0 - initial release
// ============================================================================
module da_fir5_ctrl
    import da_fir5_ctrl_pkg::*;
#(
    parameter int B   = B_DEF,
    parameter int LAT = LAT_DEF,
    parameter int WY  = WY_DEF
) (
    input wire logic       clk,
    input wire logic       reset,
    da_fir5_ctrl_if.slave  bus
);

    // Bit-plane index width and a counter wide enough for ISSUE and DRAIN
    localparam int KW   = (B > 1) ? $clog2(B) : 1;
    localparam int CMAX = (B > LAT) ? B : LAT;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [B-1:0]  taps_q [NTAPS];
    logic signed [WY-1:0] acc_q;
    logic [LAT-1:0]       tag_v_q;
    logic [KW-1:0]        tag_k_q [LAT];
    logic signed [WY-1:0] y_out_q;
    logic                 y_valid_q;

    logic                 w_accept;
    logic                 w_issue;
    logic [4:0]           w_addr;
    logic [4:0]           w_lut_data;
    logic [WY-1:0]        w_term;
    logic                 w_sign_plane;

    // ------------------------------------------------------------------
    // Handshake and status
    // ------------------------------------------------------------------
    assign bus.x_ready = (state_q == ST_IDLE) & reset;
    assign w_accept    = bus.x_valid & bus.x_ready;
    assign w_issue     = (state_q == ST_ISSUE);
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.y_out   = y_out_q;
    assign bus.y_valid = y_valid_q;
    assign bus.tbl_addr = w_addr;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and bit/drain counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                state_d = ST_ISSUE;
                cnt_d   = '0;
            end
            ST_ISSUE: begin
                if (cnt_q == CW'(B - 1)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CW'(LAT - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bit-plane mux: address bit i is bit k of tap i, zero outside ISSUE
    // ------------------------------------------------------------------
    always_comb begin
        w_addr = '0;
        if (w_issue) begin
            for (int i = 0; i < NTAPS; i++) begin
                w_addr[i] = taps_q[i][cnt_q[KW-1:0]];
            end
        end
    end

    da_lut5 #(
        .LAT    (LAT)
    ) u_lut (
        .clk    (clk),
        .reset  (reset),
        .addr_i (w_addr),
        .data_o (w_lut_data)
    );

    // Tag pipe output lines up with the table data of the same address
    assign w_term       = WY'(w_lut_data) << tag_k_q[LAT-1];
    assign w_sign_plane = (tag_k_q[LAT-1] == KW'(B - 1));

    // ------------------------------------------------------------------
    // Delay line, tag pipe, accumulator and result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                taps_q[i] <= '0;
            end
            for (int i = 0; i < LAT; i++) begin
                tag_k_q[i] <= '0;
            end
            tag_v_q   <= '0;
            acc_q     <= '0;
            y_out_q   <= '0;
            y_valid_q <= 1'b0;
        end else begin
            // Tag pipe: same depth as the table so (valid, k) meets its data
            tag_v_q[0] <= w_issue;
            tag_k_q[0] <= cnt_q[KW-1:0];
            for (int i = 1; i < LAT; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_k_q[i] <= tag_k_q[i-1];
            end

            // The sample is only guaranteed stable at the accept edge, so the
            // delay line shifts there; LOAD then starts from a clean acc.
            if (w_accept) begin
                taps_q[0] <= bus.x_in;
                for (int i = 1; i < NTAPS; i++) begin
                    taps_q[i] <= taps_q[i-1];
                end
                acc_q <= '0;
            end else if (tag_v_q[LAT-1]) begin
                if (w_sign_plane) begin
                    acc_q <= acc_q - $signed(w_term);
                end else begin
                    acc_q <= acc_q + $signed(w_term);
                end
            end

            // Result registered on leaving DONE; pulse lasts one clock
            y_valid_q <= (state_q == ST_DONE);
            if (state_q == ST_DONE) begin
                y_out_q <= acc_q;
            end
        end
    end

endmodule : da_fir5_ctrl
`default_nettype wire
